// File: rtl/median_mem_reader_pkg.sv
// Shared definitions for the median memory readout block: FSM state
// encoding, default frame geometry, address width and the bit-insert helper.
package median_mem_reader_pkg;

  localparam int ADDR_W         = 8;
  localparam int DEF_IMG_WIDTH  = 80;
  localparam int DEF_IMG_HEIGHT = 60;
  localparam int ACT_CNT_W      = 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PACK  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Return v with bit idx replaced by b.
  function automatic logic [7:0] set_bit(input logic [7:0] v,
                                         input logic [2:0] idx,
                                         input logic       b);
    logic [7:0] r;
    r      = v;
    r[idx] = b;
    return r;
  endfunction

endpackage

// File: rtl/median_mem_reader_addr_gen.sv
// raster_addr_gen: raster-order x/y pixel counter. 'clear' rewinds to (0,0),
// 'advance' steps one pixel (x wraps to 0 with y+1). 'last' flags the final
// pixel of the frame.
module raster_addr_gen
  import median_mem_reader_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y,
  output logic              last
);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_HEIGHT - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Raster counter: x runs fastest, y steps on x wrap, whole frame wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + ADDR_W'(1);
      end else begin
        x <= x + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/median_mem_reader.sv
// median_mem_reader: on a trigger pulse, reads a whole binary frame from the
// median memory in raster order, packs 8 pixels per byte (first pixel in
// bit 0) and hands bytes downstream over a valid/ready handshake.
// Optional build macro ACTIVE_COUNT_EN adds output activeCount, the number
// of '1' pixels read in the current/last frame.
module median_mem_reader
  import median_mem_reader_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              trigger,
  output logic [ADDR_W-1:0] xAddressOut,
  output logic [ADDR_W-1:0] yAddressOut,
  input  logic              medianDataIn,
  output logic [7:0]        byteOut,
  output logic              byteValid,
  input  logic              byteReady,
  output logic              busy,
  output logic              readoutDone
`ifdef ACTIVE_COUNT_EN
  ,
  output logic [ACT_CNT_W-1:0] activeCount
`endif
);

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              last_px;
  logic              kill;
  logic              trig_accept;
  logic [ADDR_W-1:0] gen_x;
  logic [ADDR_W-1:0] gen_y;
  logic              gen_last;

  // Dropping 'start' behaves exactly like reset.
  assign kill        = reset || !start;
  assign trig_accept = (state == IDLE) && trigger;

  // The generator steps past each pixel as it is fetched, so it already
  // holds the next address by the time PACK or SEND hand it to the outputs.
  raster_addr_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (kill),
    .clear  (trig_accept),
    .advance(state == FETCH),
    .x      (gen_x),
    .y      (gen_y),
    .last   (gen_last)
  );

  // Readout FSM with registered outputs; addresses only change on entry to FETCH.
  always_ff @(posedge clk) begin
    if (kill) begin
      state       <= IDLE;
      xAddressOut <= '0;
      yAddressOut <= '0;
      byteOut     <= '0;
      byteValid   <= 1'b0;
      busy        <= 1'b0;
      readoutDone <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      last_px     <= 1'b0;
    end else begin
      readoutDone <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            xAddressOut <= '0;
            yAddressOut <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          // Remember whether this is the frame's final pixel.
          last_px <= gen_last;
          state   <= PACK;
        end
        PACK: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byteOut   <= set_bit(shreg, bit_cnt, medianDataIn);
            byteValid <= 1'b1;
            state     <= SEND;
          end else begin
            shreg       <= set_bit(shreg, bit_cnt, medianDataIn);
            xAddressOut <= gen_x;
            yAddressOut <= gen_y;
            state       <= FETCH;
          end
        end
        SEND: begin
          if (byteReady) begin
            byteValid <= 1'b0;
            shreg     <= '0;
            if (last_px) begin
              busy        <= 1'b0;
              readoutDone <= 1'b1;
              state       <= DONE;
            end else begin
              xAddressOut <= gen_x;
              yAddressOut <= gen_y;
              state       <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ACTIVE_COUNT_EN
  // Count set pixels as they are packed; held from readoutDone until the next trigger.
  always_ff @(posedge clk) begin
    if (kill || trig_accept) begin
      activeCount <= '0;
    end else if (state == PACK && medianDataIn) begin
      activeCount <= activeCount + ACT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_median_mem_reader.sv
// Bench for median_mem_reader: a frame memory with one-cycle read latency,
// a negedge monitor collecting accepted bytes, and a pixel-index reference
// model deriving each expected byte straight from the frame contents.
module tb_median_mem_reader;

  localparam int W      = 80;
  localparam int H      = 60;
  localparam int NBYTES = W * H / 8;

  logic       clk = 1'b0;
  logic       reset, start, trigger, medianDataIn, byteReady;
  logic [7:0] xAddressOut, yAddressOut, byteOut;
  logic       byteValid, busy, readoutDone;
`ifdef ACTIVE_COUNT_EN
  logic [12:0] activeCount;
  logic [12:0] act_at_done;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  median_mem_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .trigger     (trigger),
    .xAddressOut (xAddressOut),
    .yAddressOut (yAddressOut),
    .medianDataIn(medianDataIn),
    .byteOut     (byteOut),
    .byteValid   (byteValid),
    .byteReady   (byteReady),
    .busy        (busy),
    .readoutDone (readoutDone)
`ifdef ACTIVE_COUNT_EN
    ,
    .activeCount (activeCount)
`endif
  );

  // Frame memory: data appears one cycle after its address.
  logic mem [0:H-1][0:W-1];
  always @(posedge clk) begin
    if (int'(yAddressOut) < H && int'(xAddressOut) < W)
      medianDataIn <= mem[yAddressOut][xAddressOut];
    else
      medianDataIn <= 1'b0;
  end

  // Monitor: a byte is taken at the next rising edge when valid and ready are high here.
  logic [7:0] got[$];
  int         acc_cyc[$];
  int         cyc = 0;
  int         done_cnt = 0;
  logic       busy_prev = 1'b0;
  logic       busy_at_done = 1'b1;
  logic       busy_pre_done = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (byteValid === 1'b1 && byteReady === 1'b1) begin
      got.push_back(byteOut);
      acc_cyc.push_back(cyc);
    end
    if (readoutDone === 1'b1) begin
      done_cnt++;
      busy_at_done  = busy;
      busy_pre_done = busy_prev;
`ifdef ACTIVE_COUNT_EN
      act_at_done = activeCount;
`endif
    end
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  // Byte k holds flat pixels 8k..8k+7, earliest in bit 0.
  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] r;
    int p;
    for (int b = 0; b < 8; b++) begin
      p    = 8 * k + b;
      r[b] = mem[p / W][p % W];
    end
    return r;
  endfunction

  task automatic fill_mem(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0:       mem[y][x] = 1'b0;
          1:       mem[y][x] = 1'b1;
          2:       mem[y][x] = (x == y);
          default: mem[y][x] = (($urandom % 2) != 0);
        endcase
  endtask

  task automatic check_frame(input string tag);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    check({tag, "_nbytes"}, got.size(), NBYTES);
    for (int k = 0; k < got.size() && k < NBYTES; k++)
      if (got[k] !== exp_byte(k)) begin
        bad++;
        if (first < 0) first = k;
      end
    check({tag, "_bad_bytes"}, bad, 0);
    if (first >= 0) check({tag, "_first_bad_byte"}, got[first], exp_byte(first));
  endtask

  task automatic wait_done(input string tag, input int start_cnt, input int bound);
    int n;
    n = 0;
    while (done_cnt == start_cnt && n < bound) begin
      tick(1);
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt != start_cnt), 1);
  endtask

  task automatic wait_bytes(input string tag, input int nb, input int bound);
    int n;
    n = 0;
    while (got.size() < nb && n < bound) begin
      tick(1);
      n++;
    end
    check({tag, "_bytes_reached"}, (got.size() >= nb), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, xAddressOut, 0);
    check({tag, "_y"}, yAddressOut, 0);
    check({tag, "_byteOut"}, byteOut, 0);
    check({tag, "_byteValid"}, byteValid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_readoutDone"}, readoutDone, 0);
  endtask

  initial begin
    int d0;
    int bad;
    int n;
    logic [7:0] hold_b, hold_x, hold_y;

    reset     = 1'b1;
    start     = 1'b1;
    trigger   = 1'b0;
    byteReady = 1'b1;
    fill_mem(0);
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // All-ones frame, ready always high.
    fill_mem(1);
    got.delete();
    acc_cyc.delete();
    d0 = done_cnt;
    pulse_trigger();
    check("ones_busy_after_trigger", busy, 1);
    wait_done("ones", d0, 15000);
    tick(3);
    check_frame("ones");
    check("ones_done_pulses", done_cnt - d0, 1);
    check("ones_busy_at_done", busy_at_done, 0);
    check("ones_busy_before_done", busy_pre_done, 1);
    bad = 0;
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] != 17) bad++;
    check("ones_byte_interval", bad, 0);
    check("ones_idle_busy", busy, 0);

    // Diagonal frame, with extra triggers while busy.
    fill_mem(2);
    got.delete();
    d0 = done_cnt;
    pulse_trigger();
    tick(50);
    pulse_trigger();
    wait_bytes("diag", 300, 8000);
    pulse_trigger();
    wait_done("diag", d0, 15000);
    tick(40);
    check("diag_byte0", got[0], 8'h01);
    check("diag_byte10", got[10], 8'h02);
    check_frame("diag");
    check("diag_done_pulses", done_cnt - d0, 1);
    check("diag_no_restart", busy, 0);

    // Random frame: 20-cycle stall on byte 3, then random backpressure.
    fill_mem(3);
    got.delete();
    d0 = done_cnt;
    pulse_trigger();
    wait_bytes("stall", 3, 200);
    byteReady = 1'b0;
    n = 0;
    while (!byteValid && n < 40) begin
      tick(1);
      n++;
    end
    check("stall_valid_seen", byteValid, 1);
    hold_b = byteOut;
    hold_x = xAddressOut;
    hold_y = yAddressOut;
    check("stall_byte3_value", hold_b, exp_byte(3));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (byteOut !== hold_b || byteValid !== 1'b1 ||
          xAddressOut !== hold_x || yAddressOut !== hold_y) bad++;
    end
    check("stall_unstable_cycles", bad, 0);
    check("stall_no_extra_bytes", got.size(), 3);
    n = 0;
    while (done_cnt == d0 && n < 30000) begin
      byteReady = (($urandom % 4) != 0);
      tick(1);
      n++;
    end
    byteReady = 1'b1;
    check("stall_done_seen", (done_cnt != d0), 1);
    tick(3);
    check_frame("stall");

    // Reset at byte 100, then start-low abort, then a clean restart.
    fill_mem(3);
    got.delete();
    pulse_trigger();
    wait_bytes("rst", 100, 3000);
    reset = 1'b1;
    tick(1);
    check_all_zero("rst_mid");
    reset = 1'b0;
    tick(3);
    check("rst_stays_idle", busy, 0);
    pulse_trigger();
    tick(30);
    start = 1'b0;
    tick(1);
    check_all_zero("start_low");
    start = 1'b1;
    tick(2);
    got.delete();
    d0 = done_cnt;
    pulse_trigger();
    check("restart_x", xAddressOut, 0);
    check("restart_y", yAddressOut, 0);
    wait_done("restart", d0, 15000);
    tick(3);
    check_frame("restart");

`ifdef ACTIVE_COUNT_EN
    // Exactly 37 set pixels at random positions.
    fill_mem(0);
    n = 0;
    while (n < 37) begin
      int p;
      p = $urandom_range(W * H - 1);
      if (!mem[p / W][p % W]) begin
        mem[p / W][p % W] = 1'b1;
        n++;
      end
    end
    got.delete();
    d0 = done_cnt;
    pulse_trigger();
    wait_done("act", d0, 15000);
    check("act_at_done", act_at_done, 37);
    tick(5);
    check("act_hold", activeCount, 37);
    check_frame("act");
    pulse_trigger();
    check("act_cleared", activeCount, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
